// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: word RAM slave on an Avalon-style bus with programmable wait states
module avalon_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_err
);
  localparam logic [31:0] SPAN = 32'd4 << ADDR_WIDTH;
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] off;
  logic [ADDR_WIDTH-1:0] idx;
  logic req, valid, enter_ack;
  assign req = read | write;
  assign off = address - BASE_ADDR;
  assign idx = off[ADDR_WIDTH+1:2];
  assign valid = (address >= BASE_ADDR) && (off < SPAN) && (address[1:0] == 2'b00) && !(read && write);
  assign waitrequest = req && (state != ACK);
  assign enter_ack = req && ((state == IDLE && WAIT_CYCLES == 1) || (state == WAIT && cnt == LAST));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      readdata <= 32'd0;
      bus_err <= 1'b0;
    end else begin
      if (enter_ack && read) readdata <= valid ? mem[idx] : 32'd0;
      if (enter_ack && !valid) bus_err <= 1'b1;
      case (state)
        IDLE: if (req) begin
          state <= (WAIT_CYCLES == 1) ? ACK : WAIT;
          cnt <= 4'd1;
        end
        WAIT: if (!req) begin
          state <= IDLE;
          cnt <= 4'd0;
        end else if (cnt == LAST) begin
          state <= ACK;
          cnt <= 4'd0;
        end else cnt <= cnt + 4'd1;
        default: begin
          state <= IDLE;
          cnt <= 4'd0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == ACK && write && valid)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
  end
endmodule
